// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU instruction sequencer.
// Holds the FSM state encoding and default geometry.
package alu_seq_pkg;

    localparam int IW_DEF    = 8;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/alu_prog_buf.sv
// Program buffer: one synchronous write port, one async read port.
// Contents are not reset; power-up value is undefined.
module alu_prog_buf
    import alu_seq_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    // store one instruction word per enabled edge
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Steps through a loaded program, handing one instruction at a time
// to the ALU with a valid/ready handshake and waiting for alu_done.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic [AW:0]   length,
    input  logic          abort,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          alu_done,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          err_q, err_d;
    logic          len_ok, last, we;
    logic [IW-1:0] rdata;

    assign len_ok = (length != '0) && (length <= LEN_MAX);
    assign last   = ({1'b0, pc_q} == (len_q - LEN_ONE));

    // writes only land while idle so a running program never changes
    assign we = load_en && (state_q == IDLE) && !RST;

    alu_prog_buf #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_buf (
        .CLK   (CLK),
        .we    (we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (rdata)
    );

    // state, pc, latched length and error pulse registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // next-state logic; abort outranks ready and alu_done
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = length;
                        pc_d    = '0;
                        state_d = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = FINISH;
                end else if (instr_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = FINISH;
                end else if (alu_done) begin
                    if (last) begin
                        state_d = FINISH;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_valid = (state_q == ISSUE);
    assign instr       = instr_valid ? rdata : '0;
    assign pc          = pc_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);
    assign error       = err_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter IW, default 8, instruction word width.
REQ-002 Parameter DEPTH, default 8, program buffer entries (power of two).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 load_en  input  1  write load_data into buffer at load_addr.
REQ-006 load_addr  input  log2(DEPTH)  buffer write address.
REQ-007 load_data  input  IW  instruction word to store.
REQ-008 start  input  1  single-cycle request to run a program.
REQ-009 length  input  log2(DEPTH)+1  number of instructions to run; sampled with start.
REQ-010 abort  input  1  terminate the running program.
REQ-011 instr  output  IW  instruction presented to ALU.
REQ-012 instr_valid  output  1  instr is valid for the ALU.
REQ-013 instr_ready  input  1  ALU accepts instr this cycle.
REQ-014 alu_done  input  1  ALU finished the last accepted instruction.
REQ-015 pc  output  log2(DEPTH)  index of current instruction.
REQ-016 busy  output  1  program running (any state except IDLE).
REQ-017 done  output  1  one-cycle pulse: program completed or aborted.
REQ-018 error  output  1  one-cycle pulse: start rejected for illegal length.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, FINISH.
REQ-020 IDLE: start with 1<=length<=DEPTH SHALL latch length, set pc=0, enter ISSUE next cycle.
REQ-021 IDLE: start with length=0 or length>DEPTH SHALL pulse error next cycle and remain IDLE.
REQ-022 ISSUE: instr_valid=1, instr=buffer[pc]; instr SHALL stay stable until instr_valid&&instr_ready.
REQ-023 ISSUE with instr_ready=1 SHALL enter WAIT next cycle; instr_valid deasserts in WAIT.
REQ-024 WAIT with alu_done=1: if pc==length-1 enter FINISH, else pc<=pc+1 and enter ISSUE.
REQ-025 alu_done outside WAIT SHALL be ignored.
REQ-026 FINISH SHALL last one cycle with done=1, then IDLE; pc holds last value.
REQ-027 abort in ISSUE or WAIT SHALL enter FINISH next cycle; abort has priority over instr_ready and alu_done in the same cycle.
REQ-028 abort in IDLE or FINISH SHALL be ignored.
REQ-029 start while busy SHALL be ignored (no error pulse).
REQ-030 load_en while busy SHALL be ignored; in IDLE the write takes effect next edge; start and load_en in the same IDLE cycle: write completes before first issue.
REQ-031 Minimum latency start->first instr_valid SHALL be 1 cycle; per instruction 2 cycles minimum (ISSUE+WAIT).
REQ-032 pc SHALL never wrap; max value length-1.

Reset
REQ-033 RST SHALL force state IDLE, pc=0, instr_valid=0, busy=0, done=0, error=0, instr=0, latched length=0.
REQ-034 RST mid-program SHALL drop instr_valid the next cycle with no done pulse.
REQ-035 RST SHALL NOT clear buffer contents; buffer power-up value is undefined.
REQ-036 RST SHALL take priority over all other inputs.

Structure
REQ-037 Package alu_seq_pkg SHALL hold the state enum, IW and DEPTH defaults.
REQ-038 Buffer SHALL be sub-module alu_prog_buf (1 write port, 1 async read port, DEPTH x IW).
REQ-039 FSM, pc counter and handshake SHALL reside in alu_sequencer.

Verification
REQ-040 Load 8'h11,8'h22,8'h33 at 0..2; start length=3; ready=1, alu_done 1 cycle after accept -> instr 11,22,33 in order, done pulses once, busy 7 cycles.
REQ-041 start length=0 and length=9 -> error pulse each, busy stays 0, instr_valid stays 0.
REQ-042 ISSUE with instr_ready low 5 cycles -> instr_valid and instr=buffer[pc] held constant 5 cycles, then advance on ready.
REQ-043 abort asserted same cycle as alu_done on pc=1 of length 4 -> FINISH next, done pulse, pc=1, no further issue.
REQ-044 RST asserted in WAIT at pc=2 -> next cycle all outputs at reset values, no done; subsequent start length=1 runs buffer[0] correctly.
REQ-045 start and load_en pulsed while busy -> no effect on run, buffer unchanged after completion.
